gcm_ae_hw_1x22_hls_deadlock_report_ctrl: RTL and testbench
==========================================================

GCM_AE_HW_1X22_HLS_DEADLOCK_REPORT_CTRL -- requirements
Module: gcm_ae_hw_1x22_hls_deadlock_report_ctrl

Interface
REQ-001 SHALL have parameter NUM_MON, default 4: number of deadlock monitor block inputs (1..16).
REQ-002 SHALL have parameter PERSIST_CYCLES, default 16: consecutive blocked cycles before a deadlock is declared (2..65535).
REQ-003 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: 0 forces IDLE, clears the counter and inhibits detection.
REQ-006 SHALL have port monitor_block, input, NUM_MON: per-monitor registered block flags.
REQ-007 SHALL have port report_valid, output, 1: deadlock report pending.
REQ-008 SHALL have port report_ready, input, 1: consumer accepts the report.
REQ-009 SHALL have port report_idx, output, 4: index of the deadlocked monitor.
REQ-010 SHALL have port report_cycle, output, 32: free-running cycle stamp at detection.
REQ-011 SHALL have port deadlock_seen, output, 1: sticky flag, set on detection.
REQ-012 SHALL have port clear_sticky, input, 1: clears deadlock_seen.
REQ-013 SHALL have port report_count, output, 8: saturating count of accepted reports.

Function
REQ-014 SHALL implement FSM states IDLE, WATCH, REPORT and WAIT_CLEAR.
- IDLE: when enable=1 and any monitor_block bit is 1, capture the lowest set index into cand_idx, load persist_cnt=1, go to WATCH.
REQ-015 In WATCH, if monitor_block[cand_idx]=1, persist_cnt SHALL increment; when it reaches PERSIST_CYCLES, the FSM SHALL go to REPORT.
- Reaching REPORT takes PERSIST_CYCLES consecutive high cycles including the capture cycle.
- report_valid SHALL be high from the next clock edge.
REQ-016 In WATCH, if monitor_block[cand_idx]=0, the FSM SHALL return to IDLE with persist_cnt=0.
- Other monitors going high SHALL NOT change cand_idx.
REQ-017 On entry to REPORT:
- report_idx SHALL be set to cand_idx.
- report_cycle SHALL be set to the cycle counter value.
- deadlock_seen SHALL be set.
REQ-018 report_valid, report_idx and report_cycle SHALL hold stable until report_valid and report_ready are both high.
REQ-019 On acceptance, report_count SHALL increment (saturating at 255) and the FSM SHALL go to WAIT_CLEAR.
REQ-020 WAIT_CLEAR SHALL go to IDLE only after monitor_block[report_idx]=0 is sampled.
- This prevents re-reporting the same persistent deadlock.
REQ-021 If report_ready is already high on the first REPORT cycle, the report SHALL be accepted in that single cycle.
REQ-022 enable=0 in WATCH or WAIT_CLEAR SHALL force IDLE next cycle.
- enable=0 in REPORT SHALL NOT drop report_valid; a pending report always completes.
REQ-023 If clear_sticky and a detection occur in the same cycle, set SHALL win.
REQ-024 The 32-bit cycle counter SHALL increment every cycle and wrap modulo 2^32.
REQ-025 The persist counter SHALL be $clog2(PERSIST_CYCLES+1) bits wide and SHALL never wrap.

Reset
REQ-026 Reset SHALL set the following:
- FSM to IDLE.
- report_valid=0, report_idx=0, report_cycle=0, deadlock_seen=0, report_count=0.
- persist_cnt=0 and the cycle counter to 0.
REQ-027 Reset asserted mid-WATCH or mid-REPORT SHALL abandon the pending report with no acceptance counted.

Configuration
REQ-028 With macro GCM_DEADLOCK_TIMESTAMP_EN defined, the cycle counter and report_cycle capture SHALL be implemented.
- Without it, report_cycle SHALL be constant 0 and no counter logic SHALL be synthesized.
- Port list is identical in both builds.

Structure
REQ-029 FSM state enum, the report_idx width constant (4) and the report_count width constant (8) SHALL live in shared package gcm_ae_hw_1x22_deadlock_pkg.
REQ-030 Lowest-index selection SHALL be a sub-module gcm_ae_hw_1x22_prio_enc (NUM_MON in, index plus any-valid out, combinational).

Verification (NUM_MON=4, PERSIST_CYCLES=16, macro defined)
REQ-031 monitor_block=4'b0100 held 20 cycles, report_ready=1 -> report_valid rises 16 cycles after first high sample; report_idx=2; report_count=1; deadlock_seen=1.
REQ-032 monitor_block[1] high 10 cycles, low 1 cycle, high 10 cycles -> no report_valid; FSM back to IDLE after the gap.
REQ-033 monitor_block=4'b1010 persistent, report_ready=0 for 30 cycles then 1 -> report_idx=1 stable throughout; exactly one acceptance; no second report while bit 1 stays high.
REQ-034 Report pending, reset pulsed for 1 cycle -> report_valid=0 and report_count=0 the cycle after reset, deadlock_seen=0.
REQ-035 Detection cycle coincides with clear_sticky=1 -> deadlock_seen=1; clear_sticky one cycle later -> deadlock_seen=0.
REQ-036 Build without GCM_DEADLOCK_TIMESTAMP_EN, rerun REQ-031 -> identical behaviour except report_cycle=0.

Source files
------------

// File: rtl/gcm_ae_hw_1x22_deadlock_pkg.sv
// Shared constants for the deadlock report controller: FSM state encoding and
// the widths of the report index and the accepted-report counter.
package gcm_ae_hw_1x22_deadlock_pkg;

  localparam int unsigned IdxW   = 4;
  localparam int unsigned CountW = 8;

  typedef logic [1:0] state_t;

  localparam state_t StIdle      = 2'd0;
  localparam state_t StWatch     = 2'd1;
  localparam state_t StReport    = 2'd2;
  localparam state_t StWaitClear = 2'd3;

endpackage

// File: rtl/gcm_ae_hw_1x22_prio_enc.sv
// Combinational lowest-index priority encoder over the monitor block flags.
module gcm_ae_hw_1x22_prio_enc
  import gcm_ae_hw_1x22_deadlock_pkg::*;
#(
  parameter int unsigned NUM_MON = 4
) (
  input  logic [NUM_MON-1:0] req_i,
  output logic [IdxW-1:0]    idx_o,
  output logic               valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_MON; i++) begin
      if (req_i[i] && !valid_o) begin
        idx_o   = IdxW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcm_ae_hw_1x22_hls_deadlock_report_ctrl.sv
// Deadlock report controller: confirms a persistently blocked monitor and hands
// out one report per episode. Define GCM_DEADLOCK_TIMESTAMP_EN for cycle stamps.
module gcm_ae_hw_1x22_hls_deadlock_report_ctrl
  import gcm_ae_hw_1x22_deadlock_pkg::*;
#(
  parameter int unsigned NUM_MON        = 4,
  parameter int unsigned PERSIST_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_MON-1:0] monitor_block,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [IdxW-1:0]    report_idx,
  output logic [31:0]        report_cycle,
  output logic               deadlock_seen,
  input  logic               clear_sticky,
  output logic [CountW-1:0]  report_count
);

  localparam int unsigned PersistW = $clog2(PERSIST_CYCLES + 1);
  localparam logic [PersistW-1:0] PersistMax = PersistW'(PERSIST_CYCLES);

  state_t              state_q, state_d;
  logic [IdxW-1:0]     cand_idx_q, cand_idx_d;
  logic [PersistW-1:0] persist_cnt_q, persist_cnt_d;
  logic [IdxW-1:0]     report_idx_q, report_idx_d;
  logic                deadlock_seen_q, deadlock_seen_d;
  logic [CountW-1:0]   report_count_q, report_count_d;

  logic [IdxW-1:0] enc_idx;
  logic            enc_any;
  logic [15:0]     mon_ext;
  logic            cand_hit, rep_hit;
  logic            enter_report, accept;

  gcm_ae_hw_1x22_prio_enc #(
    .NUM_MON (NUM_MON)
  ) u_prio_enc (
    .req_i   (monitor_block),
    .idx_o   (enc_idx),
    .valid_o (enc_any)
  );

  // Zero-extend so a 4-bit index can address any monitor count safely.
  always_comb begin
    mon_ext                = '0;
    mon_ext[NUM_MON-1:0]   = monitor_block;
  end

  assign cand_hit = mon_ext[cand_idx_q];
  assign rep_hit  = mon_ext[report_idx_q];

  always_comb begin
    state_d         = state_q;
    cand_idx_d      = cand_idx_q;
    persist_cnt_d   = persist_cnt_q;
    report_idx_d    = report_idx_q;
    report_count_d  = report_count_q;
    deadlock_seen_d = deadlock_seen_q;
    enter_report    = 1'b0;
    accept          = 1'b0;

    case (state_q)
      StIdle: begin
        persist_cnt_d = '0;
        if (enable && enc_any) begin
          cand_idx_d    = enc_idx;
          persist_cnt_d = PersistW'(1);
          state_d       = StWatch;
        end
      end
      StWatch: begin
        if (!enable || !cand_hit) begin
          persist_cnt_d = '0;
          state_d       = StIdle;
        end else begin
          persist_cnt_d = persist_cnt_q + PersistW'(1);
          if (persist_cnt_d == PersistMax) begin
            enter_report = 1'b1;
            state_d      = StReport;
          end
        end
      end
      // A pending report completes regardless of enable.
      StReport: begin
        if (report_ready) begin
          accept  = 1'b1;
          state_d = StWaitClear;
        end
      end
      StWaitClear: begin
        persist_cnt_d = '0;
        if (!enable || !rep_hit) begin
          state_d = StIdle;
        end
      end
      default: begin
        persist_cnt_d = '0;
        state_d       = StIdle;
      end
    endcase

    if (enter_report) begin
      report_idx_d = cand_idx_q;
    end
    if (accept && (report_count_q != {CountW{1'b1}})) begin
      report_count_d = report_count_q + CountW'(1);
    end
    // Detection takes priority over a simultaneous clear.
    if (enter_report) begin
      deadlock_seen_d = 1'b1;
    end else if (clear_sticky) begin
      deadlock_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      cand_idx_q      <= '0;
      persist_cnt_q   <= '0;
      report_idx_q    <= '0;
      deadlock_seen_q <= 1'b0;
      report_count_q  <= '0;
    end else begin
      state_q         <= state_d;
      cand_idx_q      <= cand_idx_d;
      persist_cnt_q   <= persist_cnt_d;
      report_idx_q    <= report_idx_d;
      deadlock_seen_q <= deadlock_seen_d;
      report_count_q  <= report_count_d;
    end
  end

`ifdef GCM_DEADLOCK_TIMESTAMP_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] report_cycle_q, report_cycle_d;

  always_comb begin
    cycle_cnt_d    = cycle_cnt_q + 32'd1;
    report_cycle_d = report_cycle_q;
    if (enter_report) begin
      report_cycle_d = cycle_cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_q    <= '0;
      report_cycle_q <= '0;
    end else begin
      cycle_cnt_q    <= cycle_cnt_d;
      report_cycle_q <= report_cycle_d;
    end
  end

  assign report_cycle = report_cycle_q;
`else
  assign report_cycle = '0;
`endif

  assign report_valid  = (state_q == StReport);
  assign report_idx    = report_idx_q;
  assign deadlock_seen = deadlock_seen_q;
  assign report_count  = report_count_q;

endmodule

// File: tb/tb_gcm_ae_hw_1x22_hls_deadlock_report_ctrl.sv
// Directed self-checking bench for the deadlock report controller (NUM_MON=4,
// PERSIST_CYCLES=16); report_cycle expectations follow GCM_DEADLOCK_TIMESTAMP_EN.
module tb_gcm_ae_hw_1x22_hls_deadlock_report_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  monitor_block;
  logic        report_valid;
  logic        report_ready;
  logic [3:0]  report_idx;
  logic [31:0] report_cycle;
  logic        deadlock_seen;
  logic        clear_sticky;
  logic [7:0]  report_count;

  int n_pass   = 0;
  int n_checks = 0;

`ifdef GCM_DEADLOCK_TIMESTAMP_EN
  localparam bit TsEn = 1'b1;
`else
  localparam bit TsEn = 1'b0;
`endif

  gcm_ae_hw_1x22_hls_deadlock_report_ctrl #(
    .NUM_MON        (4),
    .PERSIST_CYCLES (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .monitor_block (monitor_block),
    .report_valid  (report_valid),
    .report_ready  (report_ready),
    .report_idx    (report_idx),
    .report_cycle  (report_cycle),
    .deadlock_seen (deadlock_seen),
    .clear_sticky  (clear_sticky),
    .report_count  (report_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_cyc(input logic [31:0] c);
    return TsEn ? c : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    enable        = 1'b1;
    monitor_block = 4'b0000;
    report_ready  = 1'b0;
    clear_sticky  = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", 32'(report_valid), 32'd0);
    check("rst_idx", 32'(report_idx), 32'd0);
    check("rst_cycle", report_cycle, 32'd0);
    check("rst_seen", 32'(deadlock_seen), 32'd0);
    check("rst_count", 32'(report_count), 32'd0);

    // Persistent block on monitor 2, consumer always ready
    monitor_block = 4'b0100;
    report_ready  = 1'b1;
    step(15);
    check("t1_valid_early", 32'(report_valid), 32'd0);
    step(1);
    check("t1_valid", 32'(report_valid), 32'd1);
    check("t1_idx", 32'(report_idx), 32'd2);
    check("t1_cycle", report_cycle, exp_cyc(32'd15));
    check("t1_seen", 32'(deadlock_seen), 32'd1);
    step(1);
    check("t1_accepted", 32'(report_valid), 32'd0);
    check("t1_count", 32'(report_count), 32'd1);
    step(3);
    check("t1_no_rereport", 32'(report_valid), 32'd0);
    monitor_block = 4'b0000;
    step(5);
    check("t1_count_end", 32'(report_count), 32'd1);

    // Gap in the block resets persistence
    do_reset();
    monitor_block = 4'b0010;
    step(10);
    monitor_block = 4'b0000;
    step(1);
    check("t2_gap_valid", 32'(report_valid), 32'd0);
    monitor_block = 4'b0010;
    step(10);
    check("t2_after_valid", 32'(report_valid), 32'd0);
    monitor_block = 4'b0000;
    step(10);
    check("t2_end_valid", 32'(report_valid), 32'd0);
    check("t2_seen", 32'(deadlock_seen), 32'd0);

    // Back-pressure; a lower monitor joining later must not steal the candidate
    do_reset();
    monitor_block = 4'b1010;
    step(5);
    monitor_block = 4'b1011;
    step(11);
    check("t3_valid", 32'(report_valid), 32'd1);
    check("t3_idx", 32'(report_idx), 32'd1);
    check("t3_cycle", report_cycle, exp_cyc(32'd15));
    step(29);
    check("t3_valid_hold", 32'(report_valid), 32'd1);
    check("t3_idx_hold", 32'(report_idx), 32'd1);
    check("t3_cycle_hold", report_cycle, exp_cyc(32'd15));
    report_ready = 1'b1;
    step(1);
    check("t3_accepted", 32'(report_valid), 32'd0);
    check("t3_count", 32'(report_count), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("t3_no_second", 32'(report_valid), 32'd0);
    end
    check("t3_count_end", 32'(report_count), 32'd1);

    // Reset while a report is pending
    monitor_block = 4'b0000;
    step(1);
    monitor_block = 4'b0100;
    report_ready  = 1'b0;
    step(16);
    check("t4_pending", 32'(report_valid), 32'd1);
    check("t4_pending_idx", 32'(report_idx), 32'd2);
    check("t4_count_before", 32'(report_count), 32'd1);
    reset         = 1'b1;
    monitor_block = 4'b0000;
    step(1);
    reset = 1'b0;
    check("t4_valid", 32'(report_valid), 32'd0);
    check("t4_count", 32'(report_count), 32'd0);
    check("t4_seen", 32'(deadlock_seen), 32'd0);
    check("t4_idx", 32'(report_idx), 32'd0);
    check("t4_cycle", report_cycle, 32'd0);

    // Sticky set beats clear; enable low does not drop a pending report
    do_reset();
    monitor_block = 4'b0001;
    step(15);
    check("t5_seen_pre", 32'(deadlock_seen), 32'd0);
    clear_sticky = 1'b1;
    step(1);
    check("t5_set_wins", 32'(deadlock_seen), 32'd1);
    check("t5_valid", 32'(report_valid), 32'd1);
    step(1);
    check("t5_cleared", 32'(deadlock_seen), 32'd0);
    check("t5_valid_kept", 32'(report_valid), 32'd1);
    clear_sticky = 1'b0;
    enable       = 1'b0;
    step(3);
    check("t5_en0_valid", 32'(report_valid), 32'd1);
    check("t5_en0_idx", 32'(report_idx), 32'd0);
    report_ready = 1'b1;
    step(1);
    check("t5_en0_accept", 32'(report_valid), 32'd0);
    check("t5_en0_count", 32'(report_count), 32'd1);
    step(1);
    enable = 1'b1;
    step(16);
    check("t5_rearm_valid", 32'(report_valid), 32'd1);
    step(1);
    check("t5_rearm_count", 32'(report_count), 32'd2);

    // enable low inhibits detection and clears persistence
    do_reset();
    enable        = 1'b0;
    monitor_block = 4'b0001;
    report_ready  = 1'b1;
    step(20);
    check("t6_disabled", 32'(report_valid), 32'd0);
    enable = 1'b1;
    step(10);
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(10);
    check("t6_restart", 32'(report_valid), 32'd0);
    step(6);
    check("t6_detect", 32'(report_valid), 32'd1);
    check("t6_idx", 32'(report_idx), 32'd0);

    // Accepted-report counter saturates at 255
    do_reset();
    report_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      monitor_block = 4'b0001;
      step(18);
      monitor_block = 4'b0000;
      step(2);
      if (i == 254) check("t7_count_255", 32'(report_count), 32'd255);
    end
    check("t7_saturated", 32'(report_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
